// File: rtl/sfifo_ctrl.sv
// Controller for a single-port FIFO memory: pointers, fill count, write holding register
// and one-port arbitration between writes and read prefetches. Optional o_level via SFIFO_CTRL_LEVEL_EN.
module sfifo_ctrl #(
    parameter int BW     = 32,
    parameter int LGFLEN = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_wr_valid,
    input  logic [BW-1:0]     i_wr_data,
    output logic              o_wr_ready,
    output logic              o_rd_valid,
    output logic [BW-1:0]     o_rd_data,
    input  logic              i_rd_ready,
    output logic              o_full,
`ifdef SFIFO_CTRL_LEVEL_EN
    output logic [LGFLEN+1:0] o_level,
`endif
    output logic              o_mem_wr,
    output logic [LGFLEN:0]   o_mem_wr_addr,
    output logic [BW-1:0]     o_mem_data,
    output logic              o_mem_rd,
    output logic [LGFLEN:0]   o_mem_rd_addr,
    input  logic [BW-1:0]     i_mem_data
);
    localparam int              DEPTH   = 1 << LGFLEN;
    localparam logic [LGFLEN:0] DEPTH_C = DEPTH[LGFLEN:0];

    logic [LGFLEN-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LGFLEN:0]   count_q, count_d;
    logic [BW-1:0]     w_data_q;
    logic              w_valid_q, w_valid_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rr_q, rr_d;
    logic              we, re, gnt_wr, gnt_rd, accept;

    always_comb begin
        we     = w_valid_q && (count_q < DEPTH_C);
        re     = (count_q != '0) && (!rd_valid_q || i_rd_ready);
        // rr=0 lets the write win a contested cycle, rr=1 lets the read win
        gnt_wr = we && (!re || !rr_q);
        gnt_rd = re && !gnt_wr;
        accept = i_wr_valid && (!w_valid_q || gnt_wr);

        wptr_d     = gnt_wr ? wptr_q + LGFLEN'(1) : wptr_q;
        rptr_d     = gnt_rd ? rptr_q + LGFLEN'(1) : rptr_q;
        count_d    = count_q;
        if (gnt_wr)      count_d = count_q + (LGFLEN+1)'(1);
        else if (gnt_rd) count_d = count_q - (LGFLEN+1)'(1);

        w_valid_d  = w_valid_q;
        if (accept)      w_valid_d = 1'b1;
        else if (gnt_wr) w_valid_d = 1'b0;

        rd_valid_d = rd_valid_q;
        if (gnt_rd)                        rd_valid_d = 1'b1;
        else if (rd_valid_q && i_rd_ready) rd_valid_d = 1'b0;

        rr_d = (we && re) ? !rr_q : rr_q;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            w_valid_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rr_q       <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            w_valid_q  <= w_valid_d;
            rd_valid_q <= rd_valid_d;
            rr_q       <= rr_d;
        end
    end

    // Holding data needs no reset; w_valid_q qualifies it.
    always_ff @(posedge i_clk) begin
        if (accept) w_data_q <= i_wr_data;
    end

`ifdef SFIFO_CTRL_LEVEL_EN
    logic [LGFLEN+1:0] level_d;
    always_comb begin
        level_d = (LGFLEN+2)'(count_d) + (LGFLEN+2)'(w_valid_d) + (LGFLEN+2)'(rd_valid_d);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) o_level <= '0;
        else            o_level <= level_d;
    end
`endif

    assign o_wr_ready    = !w_valid_q || gnt_wr;
    assign o_rd_valid    = rd_valid_q;
    assign o_rd_data     = i_mem_data;
    assign o_full        = w_valid_q && (count_q == DEPTH_C);
    assign o_mem_wr      = gnt_wr;
    assign o_mem_wr_addr = {1'b0, wptr_q};
    assign o_mem_data    = w_data_q;
    assign o_mem_rd      = gnt_rd;
    assign o_mem_rd_addr = {1'b0, rptr_q};

endmodule

// File: tb/tb_sfifo_ctrl.sv
// Bench for sfifo_ctrl: behavioural memory plus a queue/occupancy reference model,
// directed steps followed by random traffic.
module tb_sfifo_ctrl;
    localparam int BW     = 32;
    localparam int LGFLEN = 4;
    localparam int DEPTH  = 1 << LGFLEN;

    logic              i_clk = 1'b0;
    logic              i_reset_n;
    logic              i_wr_valid;
    logic [BW-1:0]     i_wr_data;
    logic              o_wr_ready;
    logic              o_rd_valid;
    logic [BW-1:0]     o_rd_data;
    logic              i_rd_ready;
    logic              o_full;
`ifdef SFIFO_CTRL_LEVEL_EN
    logic [LGFLEN+1:0] o_level;
`endif
    logic              o_mem_wr;
    logic [LGFLEN:0]   o_mem_wr_addr;
    logic [BW-1:0]     o_mem_data;
    logic              o_mem_rd;
    logic [LGFLEN:0]   o_mem_rd_addr;
    logic [BW-1:0]     i_mem_data;

    sfifo_ctrl #(.BW(BW), .LGFLEN(LGFLEN)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
        .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .i_rd_ready(i_rd_ready),
        .o_full(o_full),
`ifdef SFIFO_CTRL_LEVEL_EN
        .o_level(o_level),
`endif
        .o_mem_wr(o_mem_wr), .o_mem_wr_addr(o_mem_wr_addr), .o_mem_data(o_mem_data),
        .o_mem_rd(o_mem_rd), .o_mem_rd_addr(o_mem_rd_addr), .i_mem_data(i_mem_data)
    );

    always #5 i_clk = ~i_clk;

    // Single-port memory with registered output that holds when not read.
    logic [BW-1:0] mem [0:2*DEPTH-1];
    always @(posedge i_clk) begin
        if (o_mem_wr) mem[o_mem_wr_addr] <= o_mem_data;
        if (o_mem_rd) i_mem_data <= mem[o_mem_rd_addr];
    end

    int            checks = 0;
    int            errors = 0;
    logic [BW-1:0] exp_q[$];
    int            occ = 0;
    logic          s_wr, s_rd, s_rv, s_wrdy, s_full, s_acc, s_cons;
    logic [LGFLEN:0] s_wa, s_ra;
    logic [BW-1:0] s_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, sample before posedge, update model at posedge.
    task automatic cyc(input logic wv, input logic [BW-1:0] wd, input logic rdy);
        i_wr_valid = wv; i_wr_data = wd; i_rd_ready = rdy;
        #1;
        s_wr = o_mem_wr; s_rd = o_mem_rd; s_wa = o_mem_wr_addr; s_ra = o_mem_rd_addr;
        s_rv = o_rd_valid; s_data = o_rd_data; s_wrdy = o_wr_ready; s_full = o_full;
        s_acc = wv && o_wr_ready;
        s_cons = o_rd_valid && rdy;
        chk("strobe_excl", 64'(s_wr & s_rd), 0);
        chk("addr_msb", 64'({s_wa[LGFLEN], s_ra[LGFLEN]}), 0);
        if (s_cons) begin
            if (exp_q.size() == 0) chk("rd_spurious", 64'(s_rv), 0);
            else                   chk("rd_data", 64'(s_data), 64'(exp_q[0]));
        end
        if (s_full) chk("full_occ", 64'(occ >= DEPTH + 1), 1);
        if (occ == DEPTH + 2) chk("cap_block", 64'(s_wrdy), 0);
`ifdef SFIFO_CTRL_LEVEL_EN
        chk("level", 64'(o_level), 64'(occ));
`endif
        @(posedge i_clk);
        if (s_acc) begin exp_q.push_back(wd); occ++; end
        if (s_cons && exp_q.size() != 0) begin void'(exp_q.pop_front()); occ--; end
        @(negedge i_clk);
    endtask

    // Reset asserted mid-cycle and held across one rising edge, released at negedge.
    task automatic rst_pulse();
        #2;
        i_reset_n = 1'b0; i_wr_valid = 1'b1; i_rd_ready = 1'b1;
        #1;
        chk("rst_rd_valid", 64'(o_rd_valid), 0);
        chk("rst_wr_ready", 64'(o_wr_ready), 1);
        chk("rst_full", 64'(o_full), 0);
        chk("rst_mem_wr", 64'(o_mem_wr), 0);
        chk("rst_mem_rd", 64'(o_mem_rd), 0);
`ifdef SFIFO_CTRL_LEVEL_EN
        chk("rst_level", 64'(o_level), 0);
`endif
        @(posedge i_clk);
        #1;
        chk("rst_hold_strobes", 64'({o_mem_wr, o_mem_rd}), 0);
        chk("rst_hold_rd_valid", 64'(o_rd_valid), 0);
        @(negedge i_clk);
        i_reset_n = 1'b1; i_wr_valid = 1'b0; i_rd_ready = 1'b0;
        exp_q.delete();
        occ = 0;
    endtask

    initial begin
        int nw;
        logic prev_wr;
        i_reset_n = 1'b1; i_wr_valid = 1'b0; i_wr_data = '0; i_rd_ready = 1'b0;

        // Reset pulse with no clock edge
        #1 i_reset_n = 1'b0;
        #1;
        chk("por_rd_valid", 64'(o_rd_valid), 0);
        chk("por_wr_ready", 64'(o_wr_ready), 1);
        chk("por_full", 64'(o_full), 0);
        chk("por_strobes", 64'({o_mem_wr, o_mem_rd}), 0);
        #1 i_reset_n = 1'b1;
        @(negedge i_clk);

        // Single word latency
        cyc(1'b1, 32'hA5A50001, 1'b1);
        chk("sw_c0_wr_ready", 64'(s_wrdy), 1);
        cyc(1'b0, '0, 1'b1);
        chk("sw_c1_mem_wr", 64'(s_wr), 1);
        chk("sw_c1_wr_addr", 64'(s_wa), 0);
        cyc(1'b0, '0, 1'b1);
        chk("sw_c2_mem_rd", 64'(s_rd), 1);
        chk("sw_c2_rd_addr", 64'(s_ra), 0);
        cyc(1'b0, '0, 1'b1);
        chk("sw_c3_rd_valid", 64'(s_rv), 1);
        chk("sw_c3_rd_data", 64'(s_data), 64'h A5A50001);
        cyc(1'b0, '0, 1'b1);
        chk("sw_c4_rd_valid", 64'(s_rv), 0);

        // Fill with no consumption: capacity DEPTH+2
        nw = 0;
        for (int k = 0; k < 40; k++) begin
            cyc(nw < 20, BW'(nw), 1'b0);
            if (s_acc) nw++;
        end
        chk("fill_accepted", 64'(nw), DEPTH + 2);
        cyc(1'b1, BW'(nw), 1'b0);
        chk("fill_full", 64'(s_full), 1);
        chk("fill_wr_ready", 64'(s_wrdy), 0);
`ifdef SFIFO_CTRL_LEVEL_EN
        chk("fill_level", 64'(o_level), DEPTH + 2);
`endif
        for (int k = 0; k < 80 && exp_q.size() != 0; k++) cyc(1'b0, '0, 1'b1);
        chk("fill_drained", 64'(exp_q.size()), 0);

        // Contested streaming from a fresh reset (rr=0)
        rst_pulse();
        nw = 0;
        prev_wr = 1'b0;
        for (int k = 0; k < 400 && (nw < 100 || exp_q.size() != 0); k++) begin
            cyc(nw < 100, 32'hC0000000 + BW'(nw), 1'b1);
            if (k == 1) chk("cs_first_wr", 64'(s_wr), 1);
            if (k == 2) chk("cs_contest_wr_first", 64'(s_wr), 1);
            if (k >= 3 && i_wr_valid) chk("cs_alternate", 64'({s_wr, s_rd}), prev_wr ? 2'b01 : 2'b10);
            prev_wr = s_wr;
            if (s_acc) nw++;
        end
        chk("cs_all_written", 64'(nw), 100);
        chk("cs_drained", 64'(exp_q.size()), 0);

        // Random traffic against the queue model
        for (int k = 0; k < 600; k++)
            cyc(($urandom % 3) != 0, $urandom, ($urandom % 2) != 0);
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) cyc(1'b0, '0, 1'b1);
        chk("rnd_drained", 64'(exp_q.size()), 0);

        // Reset mid-stream with 5 words stored
        nw = 0;
        for (int k = 0; k < 20 && nw < 5; k++) begin
            cyc(1'b1, 32'hD0000000 + BW'(nw), 1'b0);
            if (s_acc) nw++;
        end
        for (int k = 0; k < 4; k++) cyc(1'b0, '0, 1'b0);
        chk("mr_stored", 64'(occ), 5);
        rst_pulse();
        cyc(1'b1, 32'h5EED0001, 1'b0);
        cyc(1'b0, '0, 1'b0);
        chk("mr_mem_wr", 64'(s_wr), 1);
        chk("mr_wr_addr0", 64'(s_wa), 0);
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) begin
            cyc(1'b0, '0, 1'b1);
            if (s_rd) chk("mr_rd_addr0", 64'(s_ra), 0);
        end
        chk("mr_read_back", 64'(exp_q.size()), 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, '0, 1'b1);
            chk("mr_alone", 64'(s_rv), 0);
        end

`ifdef SFIFO_CTRL_LEVEL_EN
        // Level: three writes then one consume
        rst_pulse();
        cyc(1'b1, 32'h11, 1'b0);
        chk("lv_1", 64'(o_level), 1);
        cyc(1'b1, 32'h22, 1'b0);
        chk("lv_2", 64'(o_level), 2);
        cyc(1'b1, 32'h33, 1'b0);
        chk("lv_3", 64'(o_level), 3);
        for (int k = 0; k < 10 && !o_rd_valid; k++) cyc(1'b0, '0, 1'b0);
        chk("lv_head_ready", 64'(o_rd_valid), 1);
        chk("lv_3_hold", 64'(o_level), 3);
        cyc(1'b0, '0, 1'b1);
        chk("lv_consumed", 64'(s_cons), 1);
        chk("lv_after", 64'(o_level), 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sfifo_ctrl.md
# sfifo_ctrl

Controller for the single-port FIFO memory (`sfifo_mem`) that turns it into a complete synchronous FIFO. It owns the write and read pointers and the fill count, and holds a one-entry write holding register. Because the memory port can do only one access per cycle, the controller arbitrates that port between pending writes and read prefetches. The memory's registered output is exposed directly as a first-word-fall-through valid/ready read port.

## Interface
Parameters:
- `BW`, 32, data width (must match the memory `BW`)
- `LGFLEN`, 4, log2 of memory depth; DEPTH = 2^LGFLEN

Ports:
- `i_clk`  in  1  clock
- `i_reset_n`  in  1  reset, asynchronous, active-low
- `i_wr_valid`  in  1  write request
- `i_wr_data`  in  BW  write data
- `o_wr_ready`  out  1  write accepted when `i_wr_valid && o_wr_ready`
- `o_rd_valid`  out  1  `o_rd_data` holds the head word
- `o_rd_data`  out  BW  head word; wired directly from `i_mem_data`
- `i_rd_ready`  in  1  head consumed when `o_rd_valid && i_rd_ready`
- `o_full`  out  1  `w_valid && count == DEPTH`
- `o_mem_wr`  out  1  memory write strobe
- `o_mem_wr_addr`  out  LGFLEN+1  `{1'b0, wptr}`
- `o_mem_data`  out  BW  write holding register contents
- `o_mem_rd`  out  1  memory read strobe
- `o_mem_rd_addr`  out  LGFLEN+1  `{1'b0, rptr}`
- `i_mem_data`  in  BW  memory output (1-cycle latency; holds its value when not read)

## Operation
- State:
  - `wptr` and `rptr` are LGFLEN bits and wrap naturally from DEPTH-1 to 0.
  - `count` is LGFLEN+1 bits, range 0..DEPTH.
  - Write holding register `w_data`/`w_valid`.
  - `o_rd_valid` flag.
  - Round-robin bit `rr`: 0 gives writes priority, 1 gives reads priority.
- Eligibility:
  - Write-eligible: `we = w_valid && count < DEPTH`.
  - Read-eligible: `re = count > 0 && (!o_rd_valid || i_rd_ready)`.
- Grant:
  - Only one of `we`/`re` true: grant it.
  - Both true (contested): grant per `rr`, then set `rr` to favour the loser next time.
  - Uncontested cycles leave `rr` unchanged.
  - `o_mem_wr` and `o_mem_rd` are never high in the same cycle.
- Write grant:
  - `o_mem_wr`=1; `wptr++`.
  - `w_valid` clears, unless a new write is accepted in the same cycle.
- Read grant:
  - `o_mem_rd`=1; `rptr++`.
  - `o_rd_valid` is set at the next edge.
- Consume without read grant: `o_rd_valid` clears at the next edge.
- Count update: +1 on write grant, −1 on read grant, never both.
- `o_wr_ready = !w_valid || (write granted this cycle)`. This is combinational from `i_rd_ready` through arbitration.
- Accepted write loads `w_data`, sets `w_valid`.
- Ordering: strict FIFO. Total capacity is DEPTH+2 words (memory + holding register + output).

## Timing
- Reset values (asynchronous): pointers, `count`, `w_valid`, `o_rd_valid`, `rr`, `o_mem_wr`, `o_mem_rd` all 0. Consequently `o_wr_ready`=1 and `o_full`=0.
- `o_mem_*` strobes and addresses are combinational from registered state and `i_rd_ready`.
- Latency on an idle FIFO, write accepted in cycle t:
  - t+1: memory write.
  - t+2: memory read.
  - t+3: `o_rd_valid`=1.
- Streaming reads: back-to-back consumption is sustained when uncontested. A read issued in the same cycle as a consume presents the next word in the following cycle.
- Contested steady state alternates write and read grants, i.e. one access per cycle.
- Reset asserted mid-operation: all contents are discarded immediately and no memory strobe is issued while reset is low.

## Configuration
- `SFIFO_CTRL_LEVEL_EN` defined:
  - Adds output port `o_level` (LGFLEN+2 bits) = `w_valid + count + o_rd_valid`, registered, reset 0, range 0..DEPTH+2.
  - `o_level` updates in the same edge as the state it reflects.
- Undefined: the `o_level` port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset:
  - Pulse `i_reset_n` low with no clock edge.
  - Required: `o_rd_valid`=0, `o_wr_ready`=1, `o_full`=0, `o_mem_wr`=`o_mem_rd`=0.
- Single word:
  - Write 0xA5A50001 in cycle 0 with `i_rd_ready`=1.
  - Required: `o_mem_wr` at addr 0 in cycle 1; `o_mem_rd` at addr 0 in cycle 2; `o_rd_valid`=1 with 0xA5A50001 in cycle 3; `o_rd_valid`=0 in cycle 4.
- Fill, DEPTH=16:
  - `i_rd_ready`=0, offer words 0..19 continuously.
  - Required: exactly 18 accepted (words 0..17); `o_full`=1; `o_wr_ready`=0; `o_level`=18 if enabled.
  - Then drain: data 0..17 in order.
- Contested streaming:
  - Continuous writes and reads for 100 words.
  - Required: strobes alternate when both are eligible; never both high; order preserved across the address wrap 15→0; address MSB always 0.
- Reset mid-stream:
  - Drop `i_reset_n` with 5 words stored.
  - Required: outputs clear immediately.
  - After release, the next write goes to addr 0 and reads back alone.
- Level (`SFIFO_CTRL_LEVEL_EN` defined):
  - Write 3 words, consume 1.
  - Required: `o_level` sequence 1,2,3 then 2.
